// File: rtl/seg_dma_writer_if.sv
// DMA write channel between the segment writer (master) and the memory
// write buffer (slave).
//
// Handshake: dma_wr_en is a one-cycle valid. Every cycle it is high, one
// request (dma_wr_addr, dma_wr_data) is transferred, with no ready signal.
// Flow control is dma_wr_alm_full. The master may raise dma_wr_en only in the
// cycle after it saw dma_wr_alm_full low. The buffer therefore has to absorb
// one request in flight after raising dma_wr_alm_full.
// dma_wr_complete pulses once per write that memory has acknowledged.
interface seg_dma_writer_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512
);
  logic                  dma_wr_en;
  logic [ADDR_WIDTH-1:0] dma_wr_addr;
  logic [DATA_WIDTH-1:0] dma_wr_data;
  logic                  dma_wr_alm_full;
  logic                  dma_wr_complete;

  modport master (
    output dma_wr_en, dma_wr_addr, dma_wr_data,
    input  dma_wr_alm_full, dma_wr_complete
  );

  modport slave (
    input  dma_wr_en, dma_wr_addr, dma_wr_data,
    output dma_wr_alm_full, dma_wr_complete
  );
endinterface

// File: rtl/seg_dma_writer.sv
// Segment DMA writer: after go, writes SEG_LINES pattern cachelines into each
// of four segments (0..3, in order). It then waits for every write
// completion and reports done plus the completion count.
module seg_dma_writer #(
  parameter int ADDR_WIDTH = 64,
  parameter int SEG_LINES  = 16,
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wr_addr_s0,
  input  logic [ADDR_WIDTH-1:0] wr_addr_s1,
  input  logic [ADDR_WIDTH-1:0] wr_addr_s2,
  input  logic [ADDR_WIDTH-1:0] wr_addr_s3,
  input  logic                  go,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] cv_value,
  output logic [1:0]            state_dbg,
  seg_dma_writer_if.master      dma
);
  localparam int WORDS = DATA_WIDTH / 64;
  localparam int TOTAL = 4 * SEG_LINES;
  localparam logic [ADDR_WIDTH-1:0] CV_MAX     = ADDR_WIDTH'(TOTAL);
  localparam logic [15:0]           LAST_LINE  = 16'(SEG_LINES - 1);
  localparam logic [17:0]           LAST_ISSUE = 18'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DRAIN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [3:0][ADDR_WIDTH-1:0] base_q, base_d;
  logic [1:0]                 seg_q, seg_d;
  logic [15:0]                line_q, line_d;
  logic [17:0]                issued_q, issued_d;
  logic                       done_q, done_d;
  logic [ADDR_WIDTH-1:0]      cv_q, cv_d;
  logic                       en_q, en_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;

  // Each 64-bit word tags itself with line, word index and segment, so that
  // memory contents can be checked without knowing the addresses.
  function automatic logic [DATA_WIDTH-1:0] make_line(input logic [15:0] line,
                                                      input logic [1:0]  seg);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int k = 0; k < WORDS; k++) begin
      d[k*64 +: 64] = {line, 8'(k), 38'b0, seg};
    end
    return d;
  endfunction

  // Next-state, request generation and completion counting.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    seg_d    = seg_q;
    line_d   = line_q;
    issued_d = issued_q;
    done_d   = done_q;
    cv_d     = cv_q;
    en_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;

    // IDLE occurs only after reset; stray completions there are not counted.
    if (state_q != IDLE && dma.dma_wr_complete && cv_q != CV_MAX) begin
      cv_d = cv_q + ADDR_WIDTH'(1);
    end

    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          base_d   = {wr_addr_s3, wr_addr_s2, wr_addr_s1, wr_addr_s0};
          seg_d    = 2'd0;
          line_d   = 16'd0;
          issued_d = 18'd0;
          cv_d     = '0;
          done_d   = 1'b0;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (!dma.dma_wr_alm_full) begin
          en_d     = 1'b1;
          addr_d   = base_q[seg_q] + (ADDR_WIDTH'(line_q) << 6);
          data_d   = make_line(line_q, seg_q);
          issued_d = issued_q + 18'd1;
          if (line_q == LAST_LINE) begin
            line_d = 16'd0;
            seg_d  = seg_q + 2'd1;
          end else begin
            line_d = line_q + 16'd1;
          end
          if (issued_q == LAST_ISSUE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cv_q == CV_MAX) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      seg_q    <= 2'd0;
      line_q   <= 16'd0;
      issued_q <= 18'd0;
      done_q   <= 1'b0;
      cv_q     <= '0;
      en_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      seg_q    <= seg_d;
      line_q   <= line_d;
      issued_q <= issued_d;
      done_q   <= done_d;
      cv_q     <= cv_d;
      en_q     <= en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign done            = done_q;
  assign cv_value        = cv_q;
  assign state_dbg       = state_q;
  assign dma.dma_wr_en   = en_q;
  assign dma.dma_wr_addr = addr_q;
  assign dma.dma_wr_data = data_q;
endmodule

// File: tb/tb_seg_dma_writer.sv
// Directed bench for seg_dma_writer (SEG_LINES=4): a scoreboard of expected
// requests and a completion responder with a configurable delay.
module tb_seg_dma_writer;
  localparam int AW   = 64;
  localparam int DW   = 512;
  localparam int SL   = 4;
  localparam int NREQ = 4 * SL;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] wr_addr_s0, wr_addr_s1, wr_addr_s2, wr_addr_s3;
  logic          go;
  logic          done;
  logic [AW-1:0] cv_value;
  logic [1:0]    state_dbg;

  seg_dma_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dma ();

  seg_dma_writer #(.ADDR_WIDTH(AW), .SEG_LINES(SL), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_addr_s0 (wr_addr_s0),
    .wr_addr_s1 (wr_addr_s1),
    .wr_addr_s2 (wr_addr_s2),
    .wr_addr_s3 (wr_addr_s3),
    .go         (go),
    .done       (done),
    .cv_value   (cv_value),
    .state_dbg  (state_dbg),
    .dma        (dma)
  );

  // ---------------- scoreboard state ----------------
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  int comp_due[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int run_reqs = 0;
  int done_rises = 0;
  int spurious_n = 0;
  int comp_delay = 3;
  bit done_prev = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected request stream for one run: base[s] + 64*l, pattern words.
  task automatic push_run(input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                          input logic [AW-1:0] b2, input logic [AW-1:0] b3);
    logic [AW-1:0] base [4];
    logic [DW-1:0] d;
    base = '{b0, b1, b2, b3};
    for (int s = 0; s < 4; s++) begin
      for (int l = 0; l < SL; l++) begin
        exp_addr_q.push_back(base[s] + AW'(64 * l));
        d = '0;
        for (int k = 0; k < DW / 64; k++) d[k*64 +: 64] = {16'(l), 8'(k), 38'b0, 2'(s)};
        exp_data_q.push_back(d);
      end
    end
  endtask

  // ---------------- monitor + completion responder ----------------
  initial begin
    dma.dma_wr_complete = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (dma.dma_wr_en === 1'b1) begin
        run_reqs++;
        check("req_expected", DW'(exp_addr_q.size() != 0), DW'(1));
        if (exp_addr_q.size() != 0) begin
          check("req_addr", DW'(dma.dma_wr_addr), DW'(exp_addr_q.pop_front()));
          check("req_data", dma.dma_wr_data, exp_data_q.pop_front());
        end
        comp_due.push_back(cyc + comp_delay);
      end
      if (done === 1'b1 && !done_prev) done_rises++;
      done_prev = (done === 1'b1);
      if (comp_due.size() != 0 && comp_due[0] <= cyc) begin
        void'(comp_due.pop_front());
        dma.dma_wr_complete = 1'b1;
      end else if (spurious_n > 0) begin
        spurious_n--;
        dma.dma_wr_complete = 1'b1;
      end else begin
        dma.dma_wr_complete = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Pulse go with new bases, then scramble the inputs to show they are latched.
  task automatic start(input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                       input logic [AW-1:0] b2, input logic [AW-1:0] b3);
    wr_addr_s0 = b0; wr_addr_s1 = b1; wr_addr_s2 = b2; wr_addr_s3 = b3;
    push_run(b0, b1, b2, b3);
    run_reqs = 0;
    done_rises = 0;
    go = 1'b1;
    step();
    go = 1'b0;
    wr_addr_s0 = 64'hDEAD_0000; wr_addr_s1 = 64'hDEAD_1000;
    wr_addr_s2 = 64'hDEAD_2000; wr_addr_s3 = 64'hDEAD_3000;
  endtask

  task automatic wait_reqs(input int n);
    int budget;
    budget = 0;
    while (run_reqs < n && budget < 200) begin
      step();
      budget++;
    end
    check("req_timeout", DW'(run_reqs >= n), DW'(1));
  endtask

  task automatic wait_done();
    int budget;
    budget = 0;
    while (done !== 1'b1 && budget < 300) begin
      step();
      budget++;
    end
    check("done_timeout", DW'(done), DW'(1));
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_cv"}, DW'(cv_value), DW'(NREQ));
    check({tag, "_reqs"}, DW'(run_reqs), DW'(NREQ));
    check({tag, "_sb_empty"}, DW'(exp_addr_q.size()), DW'(0));
    check({tag, "_done_rises"}, DW'(done_rises), DW'(1));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_en"}, DW'(dma.dma_wr_en), DW'(0));
    check({tag, "_addr"}, DW'(dma.dma_wr_addr), DW'(0));
    check({tag, "_data"}, dma.dma_wr_data, DW'(0));
    check({tag, "_done"}, DW'(done), DW'(0));
    check({tag, "_cv"}, DW'(cv_value), DW'(0));
  endtask

  // Hard stop in case a wait loop is itself broken.
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    go = 1'b0;
    wr_addr_s0 = '0; wr_addr_s1 = '0; wr_addr_s2 = '0; wr_addr_s3 = '0;
    dma.dma_wr_alm_full = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_zero_outputs("reset");

    // Basic run, including the two-cycle latency from go to the first request.
    start(64'h1000, 64'h2000, 64'h3000, 64'h4000);
    check("latency_c1_en", DW'(dma.dma_wr_en), DW'(0));
    step();
    check("latency_c2_en", DW'(dma.dma_wr_en), DW'(1));
    wait_done();
    end_checks("basic");

    // Restart from DONE with new bases.
    start(64'h8000, 64'h9000, 64'hA000, 64'hB000);
    check("restart_done_low", DW'(done), DW'(0));
    check("restart_cv_clear", DW'(cv_value), DW'(0));
    wait_done();
    end_checks("restart");

    // Backpressure after the third request.
    start(64'h1000, 64'h2000, 64'h3000, 64'h4000);
    wait_reqs(3);
    dma.dma_wr_alm_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_en_low", DW'(dma.dma_wr_en), DW'(0));
    end
    dma.dma_wr_alm_full = 1'b0;
    wait_done();
    end_checks("backpressure");

    // go pulsed mid-run must be ignored.
    start(64'h1000, 64'h2000, 64'h3000, 64'h4000);
    wait_reqs(6);
    go = 1'b1;
    step();
    go = 1'b0;
    wait_done();
    end_checks("go_midrun");

    // Asynchronous reset after seven requests.
    start(64'h1000, 64'h2000, 64'h3000, 64'h4000);
    wait_reqs(7);
    rst = 1'b1;
    #1;
    check_zero_outputs("midrun_rst");
    exp_addr_q.delete();
    exp_data_q.delete();
    comp_due.delete();
    step();
    step();
    rst = 1'b0;
    spurious_n = 2;
    repeat (6) step();
    check("post_rst_cv", DW'(cv_value), DW'(0));
    check("post_rst_noreq", DW'(run_reqs), DW'(7));
    check("post_rst_done", DW'(done), DW'(0));
    start(64'h1000, 64'h2000, 64'h3000, 64'h4000);
    wait_done();
    end_checks("after_rst");

    // Completions overlapping requests, then spurious extras after done.
    comp_delay = 1;
    start(64'hC000, 64'hD000, 64'hE000, 64'hF000);
    wait_done();
    end_checks("overlap");
    spurious_n = 2;
    repeat (5) step();
    check("sat_cv", DW'(cv_value), DW'(NREQ));
    check("sat_done", DW'(done), DW'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
